// File: rtl/ram_access_sequencer.sv
// ---------------------------------------------------------------------------
// ram_access_sequencer
//
// Turns burst requests (start address + beat count) into single-word accesses
// on a synchronous RAM port. A read burst returns one response beat per word,
// each beat handshaken before the next RAM access. A write burst fills every
// word with the same value. Write beats are separated by one Enable-low cycle,
// so every beat is a distinct Enable pulse. A write burst returns a single
// completion beat carrying zero data.
//
// Ports
//   Clk, Rst_n        clock (rising edge) and asynchronous active-low reset
//   ReqValid/ReqReady request handshake. Accepted only in IDLE.
//   ReqWrite          1 = write fill, 0 = read
//   ReqAddr           start address. Increments modulo 2^ADDR_W.
//   ReqLen            beat count minus one (1..8 beats)
//   ReqData           fill value for write requests
//   RspValid/RspReady response handshake
//   RspData, RspLast  read data (0 on write completion), final-beat marker
//   Busy              high whenever the sequencer is not idle
//   Enable            RAM enable. High for exactly one cycle per access.
//   ReadWrite         RAM direction (1 = read, 0 = write)
//   Address, DataIn   RAM address and write data
//   DataOut           RAM read data. Sampled only in ACCESS.
//
// All outputs are registered. Each output register is loaded from the value
// that belongs to the state being entered, so the RAM controls are clean
// for the whole ACCESS cycle.
// ---------------------------------------------------------------------------
module ram_access_sequencer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [2:0]        ReqLen,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic              RspLast,
    output logic              Busy,
    output logic              Enable,
    output logic              ReadWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] DataIn,
    input  logic [DATA_W-1:0] DataOut
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Next word address. The wrap from the top word to 0 is intentional.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    // Remaining-beat counter step.
    function automatic logic [2:0] cnt_dec(input logic [2:0] c);
        return c - 3'd1;
    endfunction

    // FSM state
    state_t state_r;
    state_t next_state_s;

    // Latched request and burst progress
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        cnt_r;
    logic [DATA_W-1:0] data_r;

    logic              write_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [2:0]        cnt_nxt_s;
    logic [DATA_W-1:0] data_nxt_s;

    // Handshake qualifiers
    logic req_hs_s;
    logic rsp_hs_s;
    logic last_beat_s;

    // Output registers and their next values
    logic              req_ready_r,  req_ready_d_s;
    logic              rsp_valid_r,  rsp_valid_d_s;
    logic [DATA_W-1:0] rsp_data_r,   rsp_data_d_s;
    logic              rsp_last_r,   rsp_last_d_s;
    logic              busy_r,       busy_d_s;
    logic              enable_r,     enable_d_s;
    logic              read_write_r, read_write_d_s;
    logic [ADDR_W-1:0] address_r,    address_d_s;
    logic [DATA_W-1:0] data_in_r,    data_in_d_s;

    assign ReqReady  = req_ready_r;
    assign RspValid  = rsp_valid_r;
    assign RspData   = rsp_data_r;
    assign RspLast   = rsp_last_r;
    assign Busy      = busy_r;
    assign Enable    = enable_r;
    assign ReadWrite = read_write_r;
    assign Address   = address_r;
    assign DataIn    = data_in_r;

    // Handshake decode. The state is checked so a stale ready can never fire.
    always_comb begin
        req_hs_s    = ReqValid && req_ready_r && (state_r == ST_IDLE);
        rsp_hs_s    = rsp_valid_r && RspReady && (state_r == ST_RESP);
        last_beat_s = (cnt_r == 3'd0);
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_hs_s) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Reads respond on every beat. Writes respond only after the last beat.
                if (!write_r) begin
                    next_state_s = ST_RESP;
                end else if (last_beat_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_GAP: begin
                next_state_s = ST_ACCESS;
            end
            ST_RESP: begin
                if (rsp_hs_s && last_beat_s) begin
                    next_state_s = ST_IDLE;
                end else if (rsp_hs_s) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Burst datapath next values: load on request, step on GAP or read-beat handshake
    always_comb begin
        write_nxt_s = write_r;
        addr_nxt_s  = addr_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (req_hs_s) begin
                    write_nxt_s = ReqWrite;
                    addr_nxt_s  = ReqAddr;
                    cnt_nxt_s   = ReqLen;
                    data_nxt_s  = ReqData;
                end else begin
                    write_nxt_s = write_r;
                end
            end
            ST_GAP: begin
                addr_nxt_s = addr_inc(addr_r);
                cnt_nxt_s  = cnt_dec(cnt_r);
            end
            ST_RESP: begin
                if (rsp_hs_s && !last_beat_s) begin
                    addr_nxt_s = addr_inc(addr_r);
                    cnt_nxt_s  = cnt_dec(cnt_r);
                end else begin
                    addr_nxt_s = addr_r;
                end
            end
            default: begin
                addr_nxt_s = addr_r;
            end
        endcase
    end

    // Burst datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            write_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            cnt_r   <= 3'd0;
            data_r  <= {DATA_W{1'b0}};
        end else begin
            write_r <= write_nxt_s;
            addr_r  <= addr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // FSM output decode, computed for the state being entered
    always_comb begin
        req_ready_d_s  = (next_state_s == ST_IDLE);
        busy_d_s       = (next_state_s != ST_IDLE);
        enable_d_s     = (next_state_s == ST_ACCESS);
        rsp_valid_d_s  = (next_state_s == ST_RESP);
        // A write reaches RESP only on its last beat, so it is always last.
        rsp_last_d_s   = (next_state_s == ST_RESP) && (write_r || last_beat_s);
        read_write_d_s = 1'b0;
        address_d_s    = {ADDR_W{1'b0}};
        data_in_d_s    = {DATA_W{1'b0}};
        rsp_data_d_s   = rsp_data_r;

        // RAM controls are driven only while the access is in progress.
        if (enable_d_s) begin
            read_write_d_s = !write_nxt_s;
            address_d_s    = addr_nxt_s;
            data_in_d_s    = data_nxt_s;
        end else begin
            read_write_d_s = 1'b0;
        end

        // DataOut is only valid during ACCESS. It is ignored in every other state.
        if (state_r == ST_ACCESS) begin
            if (!write_r) begin
                rsp_data_d_s = DataOut;
            end else if (last_beat_s) begin
                rsp_data_d_s = {DATA_W{1'b0}};
            end else begin
                rsp_data_d_s = rsp_data_r;
            end
        end else begin
            rsp_data_d_s = rsp_data_r;
        end
    end

    // Output registers. All are zero in reset, including ReqReady.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            req_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {DATA_W{1'b0}};
            rsp_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            enable_r     <= 1'b0;
            read_write_r <= 1'b0;
            address_r    <= {ADDR_W{1'b0}};
            data_in_r    <= {DATA_W{1'b0}};
        end else begin
            req_ready_r  <= req_ready_d_s;
            rsp_valid_r  <= rsp_valid_d_s;
            rsp_data_r   <= rsp_data_d_s;
            rsp_last_r   <= rsp_last_d_s;
            busy_r       <= busy_d_s;
            enable_r     <= enable_d_s;
            read_write_r <= read_write_d_s;
            address_r    <= address_d_s;
            data_in_r    <= data_in_d_s;
        end
    end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ram_access_sequencer
//
// Directed bench for ram_access_sequencer. It provides a 64x4 RAM model
// driven by the DUT's RAM port. A monitor logs every Enable pulse with its
// address, direction and cycle number. Expected values are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_ram_access_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [5:0] req_addr = 6'd0;
    logic [2:0] req_len = 3'd0;
    logic [3:0] req_data = 4'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic       enable;
    logic       read_write;
    logic [5:0] address;
    logic [3:0] data_in;
    wire  [3:0] data_out;

    // RAM model and preload port
    logic [3:0] mem [0:63];
    logic       preload = 1'b0;
    logic [5:0] pl_addr = 6'd0;
    logic [3:0] pl_data = 4'd0;

    // Enable-pulse log
    int cyc = 0;
    int en_addr_q[$];
    int en_rw_q[$];
    int en_cyc_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    ram_access_sequencer #(.ADDR_W(6), .DATA_W(4)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .ReqValid  (req_valid),
        .ReqReady  (req_ready),
        .ReqWrite  (req_write),
        .ReqAddr   (req_addr),
        .ReqLen    (req_len),
        .ReqData   (req_data),
        .RspValid  (rsp_valid),
        .RspReady  (rsp_ready),
        .RspData   (rsp_data),
        .RspLast   (rsp_last),
        .Busy      (busy),
        .Enable    (enable),
        .ReadWrite (read_write),
        .Address   (address),
        .DataIn    (data_in),
        .DataOut   (data_out)
    );

    // Clock generation
    always #5 clk = ~clk;

    // RAM read port: driven only while enabled
    assign data_out = enable ? mem[address] : 4'bzzzz;

    // RAM write port, preload path and Enable-pulse monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            mem[pl_addr] <= pl_data;
        end else if (enable && !read_write) begin
            mem[address] <= data_in;
        end
        if (enable) begin
            en_addr_q.push_back(int'(address));
            en_rw_q.push_back(int'(read_write));
            en_cyc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a response beat to be offered
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check_eq({tag, "_rsp_last"},  32'(rsp_last),  32'd0);
        check_eq({tag, "_busy"},      32'(busy),      32'd0);
        check_eq({tag, "_enable"},    32'(enable),    32'd0);
        check_eq({tag, "_rw"},        32'(read_write), 32'd0);
        check_eq({tag, "_address"},   32'(address),   32'd0);
        check_eq({tag, "_data_in"},   32'(data_in),   32'd0);
    endtask

    task automatic send_req(input logic wr, input logic [5:0] a, input logic [2:0] l, input logic [3:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_len   = l;
        req_data  = d;
    endtask

    initial begin
        int base;
        int pl_list[14];

        // ---- power-on reset: outputs zero before any clock edge ----
        rst_n = 1'b0;
        #1;
        check_all_zero("por");

        // Preload: 0..7 hold i+5, 10..13 hold E, 62/63 hold 0
        for (int i = 0; i < 8; i++) pl_list[i] = i;
        for (int i = 0; i < 4; i++) pl_list[8 + i] = 10 + i;
        pl_list[12] = 62;
        pl_list[13] = 63;
        for (int i = 0; i < 14; i++) begin
            preload = 1'b1;
            pl_addr = 6'(pl_list[i]);
            if (pl_list[i] < 8)       pl_data = 4'(pl_list[i] + 5);
            else if (pl_list[i] < 20) pl_data = 4'hE;
            else                      pl_data = 4'h0;
            tick();
        end
        preload = 1'b0;
        check_eq("rst_req_ready_low", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_req_ready_before_edge", 32'(req_ready), 32'd0);
        tick();
        check_eq("rel_req_ready_after_edge", 32'(req_ready), 32'd1);
        check_eq("rel_busy", 32'(busy), 32'd0);

        // ---- single-beat read at address 5 ----
        base = en_addr_q.size();
        send_req(1'b0, 6'd5, 3'd0, 4'h0);
        tick();                         // handshake edge (cycle N)
        req_valid = 1'b0;
        check_eq("rd1_enable_n1", 32'(enable), 32'd1);
        check_eq("rd1_addr_n1",   32'(address), 32'd5);
        check_eq("rd1_rw_n1",     32'(read_write), 32'd1);
        check_eq("rd1_rspv_n1",   32'(rsp_valid), 32'd0);
        check_eq("rd1_ready_n1",  32'(req_ready), 32'd0);
        check_eq("rd1_busy_n1",   32'(busy), 32'd1);
        tick();
        check_eq("rd1_rspv_n2",   32'(rsp_valid), 32'd1);
        check_eq("rd1_data",      32'(rsp_data), 32'hA);
        check_eq("rd1_last",      32'(rsp_last), 32'd1);
        check_eq("rd1_enable_n2", 32'(enable), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("rd1_idle_rspv",  32'(rsp_valid), 32'd0);
        check_eq("rd1_idle_ready", 32'(req_ready), 32'd1);
        check_eq("rd1_idle_busy",  32'(busy), 32'd0);
        check_eq("rd1_pulses", 32'(en_addr_q.size() - base), 32'd1);

        // ---- 8-beat read from 0 with a 3-cycle stall on beat 2 ----
        base = en_addr_q.size();
        send_req(1'b0, 6'd0, 3'd7, 4'h0);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            wait_rsp("rd8");
            check_eq("rd8_data", 32'(rsp_data), 32'(b + 5));
            check_eq("rd8_last", 32'(rsp_last), 32'(b == 7));
            if (b == 1) begin
                int n0;
                n0 = en_addr_q.size();
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check_eq("rd8_stall_rspv",   32'(rsp_valid), 32'd1);
                    check_eq("rd8_stall_data",   32'(rsp_data), 32'd6);
                    check_eq("rd8_stall_last",   32'(rsp_last), 32'd0);
                    check_eq("rd8_stall_enable", 32'(enable), 32'd0);
                end
                check_eq("rd8_stall_no_pulse", 32'(en_addr_q.size() - n0), 32'd0);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        check_eq("rd8_end_busy", 32'(busy), 32'd0);
        check_eq("rd8_pulses", 32'(en_addr_q.size() - base), 32'd8);
        for (int k = 0; k < 8 && base + k < en_addr_q.size(); k++) begin
            check_eq("rd8_pulse_addr", 32'(en_addr_q[base + k]), 32'(k));
            check_eq("rd8_pulse_rw",   32'(en_rw_q[base + k]), 32'd1);
        end

        // ---- write fill at 62, four beats of 7, wrapping to 0 ----
        base = en_addr_q.size();
        send_req(1'b1, 6'd62, 3'd3, 4'h7);
        tick();
        req_valid = 1'b0;
        check_eq("wr_first_enable", 32'(enable), 32'd1);
        check_eq("wr_first_rw",     32'(read_write), 32'd0);
        check_eq("wr_first_din",    32'(data_in), 32'h7);
        wait_rsp("wr");
        check_eq("wr_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("wr_rsp_last", 32'(rsp_last), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("wr_single_beat", 32'(rsp_valid), 32'd0);
        check_eq("wr_idle_ready",  32'(req_ready), 32'd1);
        check_eq("wr_pulses", 32'(en_addr_q.size() - base), 32'd4);
        if (en_addr_q.size() - base >= 4) begin
            check_eq("wr_addr0", 32'(en_addr_q[base + 0]), 32'd62);
            check_eq("wr_addr1", 32'(en_addr_q[base + 1]), 32'd63);
            check_eq("wr_addr2", 32'(en_addr_q[base + 2]), 32'd0);
            check_eq("wr_addr3", 32'(en_addr_q[base + 3]), 32'd1);
            for (int k = 0; k < 3; k++) begin
                check_eq("wr_gap", 32'(en_cyc_q[base + k + 1] - en_cyc_q[base + k]), 32'd2);
                check_eq("wr_rw",  32'(en_rw_q[base + k]), 32'd0);
            end
        end
        check_eq("wr_mem62", 32'(mem[62]), 32'h7);
        check_eq("wr_mem63", 32'(mem[63]), 32'h7);
        check_eq("wr_mem0",  32'(mem[0]),  32'h7);
        check_eq("wr_mem1",  32'(mem[1]),  32'h7);
        check_eq("wr_mem3_untouched", 32'(mem[3]), 32'h8);

        // ---- request held while busy: not merged, taken after one idle cycle ----
        base = en_addr_q.size();
        send_req(1'b0, 6'd3, 3'd0, 4'h0);
        tick();                         // first request accepted
        send_req(1'b0, 6'd4, 3'd0, 4'h0);
        check_eq("hold_ready_access", 32'(req_ready), 32'd0);
        check_eq("hold_addr_access",  32'(address), 32'd3);
        tick();
        check_eq("hold_ready_resp", 32'(req_ready), 32'd0);
        check_eq("hold_rspv",       32'(rsp_valid), 32'd1);
        check_eq("hold_data1",      32'(rsp_data), 32'h8);
        rsp_ready = 1'b1;
        tick();                         // response handshake, ReqValid still high
        rsp_ready = 1'b0;
        check_eq("hold_idle_ready",  32'(req_ready), 32'd1);
        check_eq("hold_idle_enable", 32'(enable), 32'd0);
        check_eq("hold_idle_busy",   32'(busy), 32'd0);
        check_eq("hold_one_pulse",   32'(en_addr_q.size() - base), 32'd1);
        tick();                         // second request accepted
        req_valid = 1'b0;
        check_eq("hold_second_enable", 32'(enable), 32'd1);
        check_eq("hold_second_addr",   32'(address), 32'd4);
        tick();
        check_eq("hold_data2", 32'(rsp_data), 32'h9);
        check_eq("hold_last2", 32'(rsp_last), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("hold_done_busy", 32'(busy), 32'd0);

        // ---- reset during the GAP of a 4-beat write ----
        base = en_addr_q.size();
        send_req(1'b1, 6'd10, 3'd3, 4'h3);
        tick();                         // ACCESS beat 0
        req_valid = 1'b0;
        tick();                         // GAP, beat 0 written
        check_eq("rstgap_in_gap", 32'(enable), 32'd0);
        check_eq("rstgap_busy",   32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstgap_async");
        tick();
        tick();
        check_eq("rstgap_held_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rstgap_rel_ready", 32'(req_ready), 32'd1);
        for (int s = 0; s < 4; s++) begin
            tick();
            check_eq("rstgap_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check_eq("rstgap_pulses", 32'(en_addr_q.size() - base), 32'd1);
        check_eq("rstgap_mem10", 32'(mem[10]), 32'h3);
        check_eq("rstgap_mem11", 32'(mem[11]), 32'hE);
        check_eq("rstgap_mem12", 32'(mem[12]), 32'hE);
        check_eq("rstgap_mem13", 32'(mem[13]), 32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_access_sequencer.md
RAM_ACCESS_SEQUENCER -- requirements
Module: ram_access_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, the RAM address width (64 words).
REQ-002 The block SHALL have parameter DATA_W, default 4, the RAM data width.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 The block SHALL have port ReqValid, input, 1, the request offered.
REQ-006 The block SHALL have port ReqReady, output, 1, the request accepted when ReqValid && ReqReady.
REQ-007 The block SHALL have port ReqWrite, input, 1, where 1 = write (fill) and 0 = read.
REQ-008 The block SHALL have port ReqAddr, input, ADDR_W, the start address.
REQ-009 The block SHALL have port ReqLen, input, 3, the beat count minus 1 (1..8 beats).
REQ-010 The block SHALL have port ReqData, input, DATA_W, the fill value written to every beat of a write.
REQ-011 The block SHALL have port RspValid, output, 1, the response beat valid.
REQ-012 The block SHALL have port RspReady, input, 1, the response consumer ready.
REQ-013 The block SHALL have port RspData, output, DATA_W, the read data (0 for write completion).
REQ-014 The block SHALL have port RspLast, output, 1, marking the final beat of a request.
REQ-015 The block SHALL have port Busy, output, 1, high whenever the state is not IDLE.
REQ-016 The block SHALL have port Enable, output, 1, the RAM enable.
REQ-017 The block SHALL have port ReadWrite, output, 1, the RAM direction, where 1 = read and 0 = write.
REQ-018 The block SHALL have port Address, output, ADDR_W, the RAM address.
REQ-019 The block SHALL have port DataIn, output, DATA_W, the RAM write data.
REQ-020 The block SHALL have port DataOut, input, DATA_W, the RAM read data; it is undriven (z) while Enable = 0.

Function
REQ-021 The block SHALL implement the states IDLE, ACCESS, GAP and RESP.
REQ-022 IDLE: ReqReady = 1 and Enable = 0; on handshake, the block SHALL latch ReqWrite, ReqAddr, ReqLen and ReqData, load the beat counter with ReqLen, and go to ACCESS.
REQ-023 ACCESS: the block SHALL hold Enable = 1, ReadWrite = !write, Address = the current address and DataIn = the latched data, all registered and stable for exactly one cycle.
REQ-024 ACCESS, read: the block SHALL capture DataOut into RspData at the end of the cycle and go to RESP.
REQ-025 ACCESS, write with beats remaining: the block SHALL go to GAP.
REQ-026 ACCESS, write on the last beat: the block SHALL load RspData = 0 and go to RESP.
REQ-027 GAP: the block SHALL hold Enable = 0 for one cycle, increment the address and decrement the counter, then go to ACCESS; this guarantees each write beat is a distinct Enable pulse.
REQ-028 RESP: RspValid SHALL be 1; RspData and RspLast SHALL be held stable until RspReady is sampled high.
REQ-029 RESP handshake with the last beat: the block SHALL return to IDLE.
REQ-030 RESP handshake with read beats remaining: the block SHALL increment the address, decrement the counter and go to ACCESS.
REQ-031 Write requests SHALL produce exactly one response beat (RspLast = 1); read requests SHALL produce ReqLen + 1 beats, with RspLast = 1 only on the final one.
REQ-032 Address increment SHALL be modulo 2^ADDR_W (63 -> 0 wrap, no error).
REQ-033 The block SHALL drive Enable = 0 in every state except ACCESS, and never sample DataOut outside ACCESS.
REQ-034 ReqReady SHALL be 0 outside IDLE; requests offered while Busy wait and SHALL NOT be lost or merged.
REQ-035 RspReady held low SHALL stall indefinitely in RESP with no RAM activity.
REQ-036 Read latency SHALL be: handshake at cycle N -> ACCESS at N+1 -> RspValid at N+2.
REQ-037 A response handshake and a new ReqValid in the same cycle SHALL NOT be accepted together; the new request is taken in the following IDLE cycle.

Reset
REQ-038 On Rst_n low, the block SHALL immediately (asynchronously) set the state to IDLE.
REQ-039 During reset, Enable, ReadWrite, Address, DataIn, RspValid, RspData, RspLast and Busy SHALL all be 0, and ReqReady SHALL be 0 while Rst_n is low.
REQ-040 On the first clock edge after Rst_n rises, ReqReady SHALL be 1.
REQ-041 Reset asserted mid-request SHALL abort it: no further Enable pulse and no response beat; the partially written RAM content remains.

Verification
REQ-042 Read of 1 beat at address 5, with the RAM model holding 4'hA at address 5 -> one Enable pulse with Address = 5 and ReadWrite = 1; RspValid two cycles after the handshake with RspData = 4'hA and RspLast = 1.
REQ-043 Write fill at address 62, ReqLen = 3, ReqData = 4'h7 -> four Enable pulses at addresses 62, 63, 0, 1, each separated by one Enable-low cycle; the RAM holds 4'h7 at all four; exactly one response beat with RspData = 0 and RspLast = 1.
REQ-044 Read of 8 beats from address 0 with RspReady low for 3 cycles on beat 2 -> no Enable during the stall; RspData stable throughout; 8 beats in order; RspLast only on beat 8.
REQ-045 ReqValid held high while Busy -> ReqReady stays 0; the second request starts only after the first RspLast handshake plus one IDLE cycle.
REQ-046 Rst_n pulled low during the GAP of a 4-beat write -> outputs go to 0 immediately; only the beats already pulsed are written; ReqReady = 1 one edge after release.
REQ-047 Power-on reset -> all outputs 0 before any clock edge.
